// File: rtl/s2_cfg_writer.sv
// s2_cfg_writer
// Loads one 4-bit truth table per S2 cell from a framed nibble stream into a
// shadow register. When the whole frame is in, all tables are committed in a
// single cycle, so the cell array never sees a half-written configuration.
//
// Ports:
//   clk        - rising-edge clock
//   clr        - synchronous active-high reset
//   start      - one-cycle frame-start pulse (honoured only when idle)
//   abort      - drops the frame currently loading (honoured only in LOAD)
//   in_nib     - truth-table nibble for the next cell
//   in_valid   - in_nib is valid
//   in_ready   - a nibble is accepted this cycle when in_valid is also high
//   busy       - a frame is loading or committing
//   cfg_d      - active tables, cell i occupies bits [4i+3:4i]
//   cfg_update - one-cycle pulse on the first cycle new cfg_d is visible
//   cfg_count  - number of completed commits, wrapping
module s2_cfg_writer #(
  parameter int NCELLS = 8,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  start,
  input  logic                  abort,
  input  logic [3:0]            in_nib,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  busy,
  output logic [4*NCELLS-1:0]   cfg_d,
  output logic                  cfg_update,
  output logic [CNT_W-1:0]      cfg_count
);

  localparam int IDX_W = $clog2(NCELLS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCELLS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [4*NCELLS-1:0]  shadow_q;
  logic [4*NCELLS-1:0]  cfg_q;
  logic                 update_q;
  logic [CNT_W-1:0]     count_q;
  logic                 accept;

  // Next-state logic. Abort is checked before the handshake so that even the
  // final nibble is discarded when both arrive together.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (in_valid) begin
          accept = 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = COMMIT;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      COMMIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State, shadow and active-configuration registers. The active tables only
  // move on the edge that leaves COMMIT, which also raises the update pulse.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      cfg_q    <= '0;
      update_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      update_q <= (state_q == COMMIT);
      if (accept) begin
        shadow_q[4*idx_q +: 4] <= in_nib;
      end
      if (state_q == COMMIT) begin
        cfg_q   <= shadow_q;
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  // Handshake and status flags come from the state alone, so they carry no
  // combinational path from the inputs.
  always_comb begin
    in_ready = (state_q == LOAD);
    busy     = (state_q != IDLE);
  end

  assign cfg_d      = cfg_q;
  assign cfg_update = update_q;
  assign cfg_count  = count_q;

endmodule
